histogram_denetleyici: RTL and testbench
========================================

// Module: histogram_denetleyici
// PURPOSE
//  Sequences one frame of histogram equalization. It clears an external 256-bin histogram RAM,
//  counts M*N pixels into it, then turns it in place into a CDF and captures cdf_min.
//  It then streams the frame a second time into the equalization datapath (pixel, cdf, cdf_min),
//  and finishes once that datapath has returned M*N results.
// PARAMETERS
//  M      320  frame width in pixels
//  N      240  frame height in pixels; M*N must be < 2^18
//  VERI_W 18   histogram/CDF word width
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       asynchronous reset, active-high
//  basla_i          in   1       start pulse; honoured only in BOSTA
//  mesgul_o         out  1       high in every state except BOSTA
//  bitti_o          out  1       one-cycle pulse when the frame is complete
//  asama_o          out  3       state: 0 BOSTA,1 TEMIZLE,2 SAY,3 CDF,4 ESITLE,5 BITTI
//  pixel_gecerli_i  in   1       pixel stream valid
//  pixel_i          in   8       pixel stream data
//  pixel_hazir_o    out  1       pixel stream ready; handshake = gecerli & hazir
//  hist_adres_o     out  8       histogram RAM address
//  hist_yaz_o       out  1       histogram RAM write enable
//  hist_yaz_veri_o  out  VERI_W  histogram RAM write data
//  hist_oku_veri_i  in   VERI_W  RAM read data; valid 1 cycle after the address is driven
//  esitle_etkin_o   out  1       datapath input strobe
//  esitle_pixel_o   out  8       pixel to the datapath
//  esitle_cdf_o     out  VERI_W  cdf[pixel] to the datapath
//  esitle_cdf_min_o out  VERI_W  captured cdf_min; held constant through ESITLE
//  esitle_hazir_i   in   1       datapath result strobe; counted only in ESITLE
// BEHAVIOUR
//  - Reset (async): state BOSTA; all outputs and internal counters, sums and flags are 0.
//  - Reset mid-operation aborts the frame with no bitti_o; RAM contents are undefined.
//  - BOSTA: basla_i moves the block to TEMIZLE. basla_i is ignored in every other state.
//  - TEMIZLE: for 256 cycles, hist_yaz_o=1, adres = k (0..255), data = 0. Then go to SAY.
//  - SAY: two-phase loop per pixel.
//    - Phase A: pixel_hazir_o=1. On handshake, adres = pixel_i and pixel_i is latched.
//    - Phase B: pixel_hazir_o=0, hist_yaz_o=1, adres = latched pixel, data = hist_oku_veri_i+1.
//    - Repeated pixels are therefore safe. Max rate is 1 pixel per 2 cycles.
//    - After the Phase B write for pixel M*N-1, go to CDF.
//  - CDF: two cycles per bin k = 0..255, using an 18-bit running sum T (cleared on entering CDF).
//    - Cycle A: read bin k.
//    - Cycle B: T' = T + rd, write T' to bin k.
//    - If no minimum has been found yet and rd != 0: cdf_min = T', set the found flag.
//    - After the bin 255 write (512 cycles), go to ESITLE.
//  - ESITLE: pixel_hazir_o=1 while sent < M*N; no RAM writes.
//    - A handshake in cycle t drives adres = pixel_i.
//    - In cycle t+1: esitle_etkin_o=1, esitle_pixel_o = latched pixel, esitle_cdf_o = hist_oku_veri_i.
//    - Back-to-back handshakes are allowed, giving 1 pixel per cycle.
//    - esitle_hazir_i pulses are counted. When the count reaches M*N, go to BITTI.
//  - BITTI: bitti_o=1 for exactly one cycle, then return to BOSTA.
//    - esitle_cdf_min_o holds its value until the next TEMIZLE.
//  - Outside SAY and ESITLE, pixel_hazir_o=0 and the pixel input is ignored.
//  - Pixel counters are 18-bit. Sum width rule: T <= M*N always, so no saturation is needed.
// TESTING (bench uses M=4, N=2)
//  1. Reset mid-run: all outputs 0, asama_o=0. After a new basla_i, all 256 bins read 0 after TEMIZLE.
//  2. Frame {5,5,5,10,10,200,200,200}:
//     - After CDF: bins 5/10/200 = 3/5/8 and bin 255 = 8; cdf_min = 3.
//     - ESITLE: esitle_cdf_o sequence = 3,3,3,5,5,8,8,8.
//  3. 8 pixels of value 7 with gecerli held high:
//     - pixel_hazir_o alternates 1,0 in SAY; bin 7 = 8; cdf_min = 8.
//  4. Apply basla_i while in SAY and again in CDF: ignored, state sequence unchanged.
//  5. ESITLE with 2-cycle gecerli gaps: each esitle_etkin_o occurs exactly 1 cycle after its handshake.
//     Delay esitle_hazir_i by 23 cycles; bitti_o fires 1 cycle after the 8th hazir.
//  6. Assert rst_i during CDF:
//     - Outputs are 0 immediately; bitti_o is never pulsed.
//     - A full rerun of frame 2 gives an identical result.

Source files
------------

// File: rtl/histogram_denetleyici_if.sv
// rtl/histogram_denetleyici_if.sv - pixel stream, histogram RAM and equalization datapath bundle
// master is the controller side; slave is the RAM/datapath/pixel source side.
interface histogram_denetleyici_if #(
  parameter int VERI_W = 18
);
  logic              pixel_gecerli_i;
  logic [7:0]        pixel_i;
  logic              pixel_hazir_o;
  logic [7:0]        hist_adres_o;
  logic              hist_yaz_o;
  logic [VERI_W-1:0] hist_yaz_veri_o;
  logic [VERI_W-1:0] hist_oku_veri_i;
  logic              esitle_etkin_o;
  logic [7:0]        esitle_pixel_o;
  logic [VERI_W-1:0] esitle_cdf_o;
  logic [VERI_W-1:0] esitle_cdf_min_o;
  logic              esitle_hazir_i;

  modport master (
    input  pixel_gecerli_i, pixel_i, hist_oku_veri_i, esitle_hazir_i,
    output pixel_hazir_o, hist_adres_o, hist_yaz_o, hist_yaz_veri_o,
           esitle_etkin_o, esitle_pixel_o, esitle_cdf_o, esitle_cdf_min_o
  );

  modport slave (
    output pixel_gecerli_i, pixel_i, hist_oku_veri_i, esitle_hazir_i,
    input  pixel_hazir_o, hist_adres_o, hist_yaz_o, hist_yaz_veri_o,
           esitle_etkin_o, esitle_pixel_o, esitle_cdf_o, esitle_cdf_min_o
  );
endinterface

// File: rtl/histogram_denetleyici.sv
// rtl/histogram_denetleyici.sv - histogram equalization frame sequencer
// Clears the histogram RAM, counts a frame, builds the CDF in place, then replays the frame.
module histogram_denetleyici #(
  parameter int M      = 320,
  parameter int N      = 240,
  parameter int VERI_W = 18
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       basla_i,
  output logic       mesgul_o,
  output logic       bitti_o,
  output logic [2:0] asama_o,
  histogram_denetleyici_if.master bus
);

  localparam logic [17:0] PIX_SAYISI = 18'(M * N);
  localparam logic [17:0] SON_PIX    = PIX_SAYISI - 18'd1;

  typedef enum logic [2:0] {
    BOSTA   = 3'd0,
    TEMIZLE = 3'd1,
    SAY     = 3'd2,
    CDF     = 3'd3,
    ESITLE  = 3'd4,
    BITTI   = 3'd5
  } durum_t;

  durum_t            durum_q, durum_d;
  logic [7:0]        bin_q;
  logic              faz_q;
  logic [17:0]       pix_say_q;
  logic [17:0]       sonuc_say_q;
  logic [7:0]        pix_q;
  logic [VERI_W-1:0] toplam_q;
  logic [VERI_W-1:0] cdf_min_q;
  logic              bulundu_q;
  logic              etkin_q;
  logic [VERI_W-1:0] toplam_yeni;
  logic              el_sikisma;

  assign toplam_yeni = toplam_q + bus.hist_oku_veri_i;
  assign el_sikisma  = bus.pixel_gecerli_i & bus.pixel_hazir_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d             = durum_q;
    bus.pixel_hazir_o   = 1'b0;
    bus.hist_adres_o    = '0;
    bus.hist_yaz_o      = 1'b0;
    bus.hist_yaz_veri_o = '0;
    bitti_o             = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (basla_i) durum_d = TEMIZLE;
      end
      TEMIZLE: begin
        bus.hist_yaz_o   = 1'b1;
        bus.hist_adres_o = bin_q;
        if (bin_q == 8'hFF) durum_d = SAY;
      end
      SAY: begin
        if (!faz_q) begin
          bus.pixel_hazir_o = 1'b1;
          bus.hist_adres_o  = bus.pixel_i;
        end else begin
          // Read-modify-write on the latched pixel; RAM data arrived this cycle.
          bus.hist_yaz_o      = 1'b1;
          bus.hist_adres_o    = pix_q;
          bus.hist_yaz_veri_o = bus.hist_oku_veri_i + 1'b1;
          if (pix_say_q == SON_PIX) durum_d = CDF;
        end
      end
      CDF: begin
        bus.hist_adres_o = bin_q;
        if (faz_q) begin
          bus.hist_yaz_o      = 1'b1;
          bus.hist_yaz_veri_o = toplam_yeni;
          if (bin_q == 8'hFF) durum_d = ESITLE;
        end
      end
      ESITLE: begin
        bus.pixel_hazir_o = (pix_say_q < PIX_SAYISI);
        bus.hist_adres_o  = bus.pixel_i;
        if (bus.esitle_hazir_i && (sonuc_say_q == SON_PIX)) durum_d = BITTI;
      end
      BITTI: begin
        bitti_o = 1'b1;
        durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q       <= '0;
      faz_q       <= 1'b0;
      pix_say_q   <= '0;
      sonuc_say_q <= '0;
      pix_q       <= '0;
      toplam_q    <= '0;
      cdf_min_q   <= '0;
      bulundu_q   <= 1'b0;
      etkin_q     <= 1'b0;
    end else begin
      etkin_q <= 1'b0;
      case (durum_q)
        BOSTA: begin
          if (basla_i) begin
            bin_q     <= '0;
            cdf_min_q <= '0;
            bulundu_q <= 1'b0;
          end
        end
        TEMIZLE: begin
          bin_q     <= bin_q + 8'd1;
          faz_q     <= 1'b0;
          pix_say_q <= '0;
        end
        SAY: begin
          if (!faz_q) begin
            if (el_sikisma) begin
              pix_q <= bus.pixel_i;
              faz_q <= 1'b1;
            end
          end else begin
            faz_q <= 1'b0;
            if (pix_say_q == SON_PIX) begin
              pix_say_q <= '0;
              bin_q     <= '0;
              toplam_q  <= '0;
              bulundu_q <= 1'b0;
            end else begin
              pix_say_q <= pix_say_q + 18'd1;
            end
          end
        end
        CDF: begin
          faz_q <= ~faz_q;
          if (faz_q) begin
            toplam_q <= toplam_yeni;
            bin_q    <= bin_q + 8'd1;
            // First non-empty bin gives cdf_min.
            if (!bulundu_q && (bus.hist_oku_veri_i != '0)) begin
              cdf_min_q <= toplam_yeni;
              bulundu_q <= 1'b1;
            end
            if (bin_q == 8'hFF) begin
              pix_say_q   <= '0;
              sonuc_say_q <= '0;
            end
          end
        end
        ESITLE: begin
          if (el_sikisma) begin
            pix_q     <= bus.pixel_i;
            pix_say_q <= pix_say_q + 18'd1;
            etkin_q   <= 1'b1;
          end
          if (bus.esitle_hazir_i) sonuc_say_q <= sonuc_say_q + 18'd1;
        end
        default: ;
      endcase
    end
  end

  assign mesgul_o             = (durum_q != BOSTA);
  assign asama_o              = durum_q;
  assign bus.esitle_etkin_o   = etkin_q;
  assign bus.esitle_pixel_o   = etkin_q ? pix_q : 8'd0;
  assign bus.esitle_cdf_o     = etkin_q ? bus.hist_oku_veri_i : '0;
  assign bus.esitle_cdf_min_o = cdf_min_q;

endmodule

// File: tb/tb_histogram_denetleyici.sv
// tb/tb_histogram_denetleyici.sv - directed bench for the histogram equalization sequencer
// Bench owns the histogram RAM and a delayed-result datapath stand-in.
module tb_histogram_denetleyici;

  localparam int VERI_W = 18;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       basla_i = 1'b0;
  logic       mesgul_o;
  logic       bitti_o;
  logic [2:0] asama_o;

  histogram_denetleyici_if #(.VERI_W(VERI_W)) bus ();

  histogram_denetleyici #(.M(4), .N(2), .VERI_W(VERI_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .basla_i (basla_i),
    .mesgul_o(mesgul_o),
    .bitti_o (bitti_o),
    .asama_o (asama_o),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [VERI_W-1:0] mem [256];
  logic [VERI_W-1:0] rd_q = '0;
  logic              doldur = 1'b0;
  logic [31:0]       sr;
  logic [4:0]        gecikme = 5'd1;

  always @(posedge clk_i) begin
    if (doldur) begin
      for (int i = 0; i < 256; i++) mem[i] <= VERI_W'(i + 1);
    end else if (bus.hist_yaz_o) begin
      mem[bus.hist_adres_o] <= bus.hist_yaz_veri_o;
    end
    rd_q <= mem[bus.hist_adres_o];
  end
  assign bus.hist_oku_veri_i = rd_q;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sr <= '0;
    else       sr <= {sr[30:0], bus.esitle_etkin_o};
  end
  assign bus.esitle_hazir_i = sr[gecikme - 5'd1];

  int dongu = 0;
  always @(posedge clk_i) dongu <= dongu + 1;

  int hs_q[$];
  int etkin_dq[$];
  int cdf_q[$];
  int pix_dq[$];
  int hazir_son   = -1;
  int bitti_dongu = -1;
  int bitti_sayisi = 0;

  always @(negedge clk_i) begin
    #4;
    if (asama_o == 3'd4 && bus.pixel_gecerli_i && bus.pixel_hazir_o) hs_q.push_back(dongu);
    if (bus.esitle_etkin_o) begin
      etkin_dq.push_back(dongu);
      cdf_q.push_back(int'(bus.esitle_cdf_o));
      pix_dq.push_back(int'(bus.esitle_pixel_o));
    end
    if (asama_o == 3'd4 && bus.esitle_hazir_i) hazir_son = dongu;
    if (bitti_o) begin
      bitti_dongu = dongu;
      bitti_sayisi++;
    end
  end

  logic [77:0] tum_cikis;
  assign tum_cikis = {mesgul_o, bitti_o, asama_o, bus.pixel_hazir_o, bus.hist_adres_o,
                      bus.hist_yaz_o, bus.hist_yaz_veri_o, bus.esitle_etkin_o,
                      bus.esitle_pixel_o, bus.esitle_cdf_o, bus.esitle_cdf_min_o};

  int karsilastirma = 0;
  int uyumsuz = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    karsilastirma++;
    if (gozlenen !== beklenen) begin
      uyumsuz++;
      $display("FAIL %s: gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(negedge clk_i);
    #1;
  endtask

  task automatic basla_ver();
    basla_i = 1'b1;
    adim();
    basla_i = 1'b0;
  endtask

  task automatic bekle_durum(input logic [2:0] s, input int butce, input string etiket);
    int n = 0;
    #1;
    while (asama_o != s && n < butce) begin
      adim();
      #1;
      n++;
    end
    kontrol(etiket, 32'(asama_o), 32'(s));
  endtask

  task automatic pixel_gonder(input logic [7:0] px [8], input int bosluk);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < bosluk; g++) begin
        bus.pixel_gecerli_i = 1'b0;
        adim();
      end
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i = px[i];
      #1;
      for (int s = 0; s < 50 && !bus.pixel_hazir_o; s++) begin
        adim();
        #1;
      end
      adim();
    end
    bus.pixel_gecerli_i = 1'b0;
  endtask

  task automatic kayit_temizle();
    hs_q.delete();
    etkin_dq.delete();
    cdf_q.delete();
    pix_dq.delete();
    hazir_son = -1;
    bitti_dongu = -1;
  endtask

  logic [7:0] kare2 [8] = '{8'd5, 8'd5, 8'd5, 8'd10, 8'd10, 8'd200, 8'd200, 8'd200};
  logic [7:0] kare7 [8] = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
  int beklenen_cdf [8] = '{3, 3, 3, 5, 5, 8, 8, 8};

  task automatic kare2_calistir(input string on);
    basla_ver();
    bekle_durum(3'd2, 300, {on, "_say"});
    pixel_gonder(kare2, 0);
    bekle_durum(3'd4, 600, {on, "_esitle"});
    kontrol({on, "_bin5"},   32'(mem[5]),   32'd3);
    kontrol({on, "_bin10"},  32'(mem[10]),  32'd5);
    kontrol({on, "_bin200"}, 32'(mem[200]), 32'd8);
    kontrol({on, "_bin255"}, 32'(mem[255]), 32'd8);
    kontrol({on, "_bin4"},   32'(mem[4]),   32'd0);
    kontrol({on, "_cdfmin"}, 32'(bus.esitle_cdf_min_o), 32'd3);
    kayit_temizle();
    gecikme = 5'd1;
    pixel_gonder(kare2, 0);
    bekle_durum(3'd0, 100, {on, "_bosta"});
    kontrol({on, "_adet"}, 32'(cdf_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      kontrol($sformatf("%s_cdf%0d", on, i), (cdf_q.size() > i) ? 32'(cdf_q[i]) : 32'hFFFF_FFFF,
              32'(beklenen_cdf[i]));
    end
    kontrol({on, "_pix5"}, (pix_dq.size() > 5) ? 32'(pix_dq[5]) : 32'hFFFF_FFFF, 32'd200);
    kontrol({on, "_cdfmin_tut"}, 32'(bus.esitle_cdf_min_o), 32'd3);
  endtask

  initial begin
    int nz;
    int b0;
    logic [15:0] hz;
    bus.pixel_gecerli_i = 1'b0;
    bus.pixel_i = 8'd0;

    // Reset state, then a reset in the middle of TEMIZLE.
    adim();
    adim();
    #1;
    kontrol("reset_cikis", 32'(|tum_cikis), 32'd0);
    rst_i = 1'b0;
    adim();
    basla_ver();
    for (int i = 0; i < 20; i++) adim();
    #1;
    kontrol("temizle_asama", 32'(asama_o), 32'd1);
    kontrol("temizle_mesgul", 32'(mesgul_o), 32'd1);
    rst_i = 1'b1;
    #1;
    kontrol("async_reset_cikis", 32'(|tum_cikis), 32'd0);
    adim();
    rst_i = 1'b0;
    doldur = 1'b1;
    adim();
    doldur = 1'b0;
    adim();
    basla_ver();
    bekle_durum(3'd2, 300, "t1_say");
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != '0) nz++;
    kontrol("temizle_sifir", 32'(nz), 32'd0);
    // Leave SAY cleanly by resetting; this frame is not used further.
    rst_i = 1'b1;
    adim();
    rst_i = 1'b0;
    adim();

    // Frame {5,5,5,10,10,200,200,200}.
    kare2_calistir("k2");
    kontrol("k2_bitti_sayisi", 32'(bitti_sayisi), 32'd1);

    // Eight 7s with gecerli held high and basla held during SAY and CDF.
    basla_ver();
    bekle_durum(3'd2, 300, "k7_say");
    basla_i = 1'b1;
    hz = '0;
    for (int i = 0; i < 16; i++) begin
      bus.pixel_gecerli_i = 1'b1;
      bus.pixel_i = 8'd7;
      #1;
      hz = {hz[14:0], bus.pixel_hazir_o};
      adim();
    end
    bus.pixel_gecerli_i = 1'b0;
    #1;
    kontrol("k7_hazir_desen", 32'(hz), 32'h0000_AAAA);
    kontrol("k7_cdf_giris", 32'(asama_o), 32'd3);
    for (int i = 0; i < 511; i++) adim();
    #1;
    kontrol("k7_cdf_son", 32'(asama_o), 32'd3);
    adim();
    #1;
    kontrol("k7_esitle_giris", 32'(asama_o), 32'd4);
    basla_i = 1'b0;
    kontrol("k7_bin7", 32'(mem[7]), 32'd8);
    kontrol("k7_bin6", 32'(mem[6]), 32'd0);
    kontrol("k7_bin255", 32'(mem[255]), 32'd8);
    kontrol("k7_cdfmin", 32'(bus.esitle_cdf_min_o), 32'd8);

    // Gapped ESITLE stream with results returning 23 cycles late.
    kayit_temizle();
    gecikme = 5'd23;
    pixel_gonder(kare7, 2);
    bekle_durum(3'd0, 200, "k7_bosta");
    kontrol("k7_hs_adet", 32'(hs_q.size()), 32'd8);
    kontrol("k7_etkin_adet", 32'(etkin_dq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      kontrol($sformatf("k7_etkin_gecikme%0d", i),
              (etkin_dq.size() > i && hs_q.size() > i) ? 32'(etkin_dq[i] - hs_q[i]) : 32'hFFFF_FFFF, 32'd1);
    end
    kontrol("k7_cdf0", (cdf_q.size() > 0) ? 32'(cdf_q[0]) : 32'hFFFF_FFFF, 32'd8);
    kontrol("k7_pix7", (pix_dq.size() > 7) ? 32'(pix_dq[7]) : 32'hFFFF_FFFF, 32'd7);
    kontrol("k7_hazir_gecikme", (etkin_dq.size() > 7) ? 32'(hazir_son - etkin_dq[7]) : 32'hFFFF_FFFF, 32'd23);
    kontrol("k7_bitti_zaman", 32'(bitti_dongu - hazir_son), 32'd1);
    kontrol("k7_bitti_sayisi", 32'(bitti_sayisi), 32'd2);

    // Reset during CDF, then a full rerun of frame 2.
    basla_ver();
    bekle_durum(3'd2, 300, "r_say");
    pixel_gonder(kare2, 0);
    bekle_durum(3'd3, 50, "r_cdf");
    for (int i = 0; i < 10; i++) adim();
    b0 = bitti_sayisi;
    rst_i = 1'b1;
    #1;
    kontrol("r_cikis_sifir", 32'(|tum_cikis), 32'd0);
    for (int i = 0; i < 3; i++) adim();
    rst_i = 1'b0;
    for (int i = 0; i < 600; i++) adim();
    kontrol("r_bitti_yok", 32'(bitti_sayisi - b0), 32'd0);
    kontrol("r_bosta", 32'(asama_o), 32'd0);
    kare2_calistir("r2");
    kontrol("r2_bitti_sayisi", 32'(bitti_sayisi), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, uyumsuz);
    $finish;
  end

endmodule
